// File: rtl/ram_port_arbiter.sv
// Request/grant arbiter and sequencer for the shared single-port feature/weight RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2 > 3.
module ram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 256,
  parameter int RD_LAT    = 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [3:0]          Req,
  input  logic [3:0]          Last,
  input  logic [3:0]          WrEn,
  input  logic [4*ADDR_W-1:0] Addr,
  input  logic [4*DATA_W-1:0] WrData,
  output logic [3:0]          Gnt,
  output logic [ADDR_W-1:0]   AddressToRAM,
  output logic                WriteEnableToRAM,
  output logic                ReadEnableToRAM,
  output logic [DATA_W-1:0]   DataToRAM,
  input  logic [DATA_W-1:0]   RamRdData,
  output logic [3:0]          RdValid,
  output logic [DATA_W-1:0]   RdData,
  output logic                Busy,
  output logic                ForcedRelease
);

  localparam int CNT_W = $clog2(MAX_BURST);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arbStateE;

  arbStateE             state;
  logic [1:0]           owner;
  logic [CNT_W-1:0]     beatCnt;
  logic [1:0]           rdOwner;
  logic [RD_LAT-1:0]    rdPipeV;
  logic [RD_LAT-1:0][1:0] rdPipeId;

  logic                 anyReq;
  logic [1:0]           winner;
  logic                 ownReq;
  logic                 ownLast;
  logic                 ownWr;
  logic [ADDR_W-1:0]    ownAddr;
  logic [DATA_W-1:0]    ownData;
  logic                 beatAcc;
  logic                 capHit;
  logic                 releaseNow;

  // Handshake: a beat transfers on a cycle where Gnt[i] && Req[i]; Req[i] doubles as beat-valid,
  // and dropping Req[i] while granted abandons the burst and returns the RAM to IDLE.
  assign anyReq  = |Req;
  assign ownReq  = Req[owner];
  assign ownLast = Last[owner];
  assign ownWr   = WrEn[owner];
  assign ownAddr = Addr[owner*ADDR_W +: ADDR_W];
  assign ownData = WrData[owner*DATA_W +: DATA_W];

  assign beatAcc    = (state == OWN) && ownReq;
  assign capHit     = (beatCnt == CNT_W'(MAX_BURST - 1));
  assign releaseNow = (state == OWN) && (!ownReq || ownLast || capHit);

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rrPtr;

  // Highest priority goes to the requester just after the previous owner.
  always_comb begin
    logic [1:0] idx;
    winner = 2'd0;
    idx    = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = rrPtr + 2'(k + 1);
      if (Req[idx]) winner = idx;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rrPtr <= 2'd3;
    end else if ((state == IDLE) && anyReq) begin
      rrPtr <= winner;
    end
  end
`else
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (Req[k]) winner = 2'(k);
    end
  end
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state            <= IDLE;
      owner            <= 2'd0;
      beatCnt          <= '0;
      Gnt              <= 4'b0000;
      Busy             <= 1'b0;
      AddressToRAM     <= '0;
      DataToRAM        <= '0;
      WriteEnableToRAM <= 1'b0;
      ReadEnableToRAM  <= 1'b0;
      ForcedRelease    <= 1'b0;
      rdOwner          <= 2'd0;
    end else begin
      WriteEnableToRAM <= 1'b0;
      ReadEnableToRAM  <= 1'b0;
      ForcedRelease    <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            state   <= OWN;
            owner   <= winner;
            beatCnt <= '0;
            Gnt     <= 4'b0001 << winner;
            Busy    <= 1'b1;
          end
        end
        OWN: begin
          if (beatAcc) begin
            AddressToRAM     <= ownAddr;
            DataToRAM        <= ownData;
            WriteEnableToRAM <= ownWr;
            ReadEnableToRAM  <= !ownWr;
            rdOwner          <= owner;
            beatCnt          <= beatCnt + CNT_W'(1);
            // Last on the capped beat is an ordinary end of burst, not a revocation.
            if (capHit && !ownLast) ForcedRelease <= 1'b1;
          end
          if (releaseNow) begin
            state <= IDLE;
            Gnt   <= 4'b0000;
            Busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return tags travel with each strobe so returns land on the issuer after ownership moves on.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rdPipeV  <= '0;
      rdPipeId <= '0;
    end else begin
      rdPipeV[0]  <= ReadEnableToRAM;
      rdPipeId[0] <= rdOwner;
      for (int i = 1; i < RD_LAT; i++) begin
        rdPipeV[i]  <= rdPipeV[i-1];
        rdPipeId[i] <= rdPipeId[i-1];
      end
    end
  end

  assign RdValid = rdPipeV[RD_LAT-1] ? (4'b0001 << rdPipeId[RD_LAT-1]) : 4'b0000;
  assign RdData  = RamRdData;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter (MAX_BURST=4, RD_LAT=2) with a transaction-level model.
module tb_ram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int RL = 2;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic [3:0]      Req = '0, Last = '0, WrEn = '0;
  logic [AW-1:0]   tAddr[4];
  logic [DW-1:0]   tData[4];
  logic [4*AW-1:0] Addr;
  logic [4*DW-1:0] WrData;
  logic [DW-1:0]   RamRdData = '0;
  logic [3:0]      Gnt, RdValid;
  logic [AW-1:0]   AddressToRAM;
  logic [DW-1:0]   DataToRAM, RdData;
  logic            WriteEnableToRAM, ReadEnableToRAM, Busy, ForcedRelease;

  always_comb begin
    Addr   = {tAddr[3], tAddr[2], tAddr[1], tAddr[0]};
    WrData = {tData[3], tData[2], tData[1], tData[0]};
  end

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .RD_LAT(RL)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Last(Last), .WrEn(WrEn), .Addr(Addr), .WrData(WrData),
    .Gnt(Gnt), .AddressToRAM(AddressToRAM), .WriteEnableToRAM(WriteEnableToRAM),
    .ReadEnableToRAM(ReadEnableToRAM), .DataToRAM(DataToRAM), .RamRdData(RamRdData),
    .RdValid(RdValid), .RdData(RdData), .Busy(Busy), .ForcedRelease(ForcedRelease)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            mOwn = 0;
  int            mOwner = 0;
  int            mBeats = 0;
  int            mLast = 3;
  logic [3:0]    eGnt = '0;
  logic [AW-1:0] eAddr = '0;
  logic [DW-1:0] eData = '0;
  logic          eWe = 0, eRe = 0, eBusy = 0, eForced = 0;
  int            dueQ[$];
  logic [1:0]    exp_q[$];

  function automatic int pick(input logic [3:0] r, input int last);
    int w = 0;
    bit found = 0;
`ifdef ARB_ROUND_ROBIN_EN
    for (int off = 1; off <= 4; off++)
      if (!found && r[(last + off) % 4]) begin
        w = (last + off) % 4;
        found = 1;
      end
`else
    for (int i = 0; i < 4; i++)
      if (!found && r[i]) begin
        w = i;
        found = 1;
      end
`endif
    return w;
  endfunction

  task automatic model_reset();
    mOwn = 0; mOwner = 0; mBeats = 0; mLast = 3;
    eGnt = '0; eAddr = '0; eData = '0; eWe = 0; eRe = 0; eBusy = 0; eForced = 0;
    dueQ.delete();
    exp_q.delete();
  endtask

  task automatic model_step();
    cyc++;
    eWe = 0; eRe = 0; eForced = 0;
    if (!mOwn) begin
      if (Req != 4'b0) begin
        mOwner = pick(Req, mLast);
        mLast = mOwner;
        mOwn = 1;
        mBeats = 0;
      end
    end else if (Req[mOwner]) begin
      eAddr = tAddr[mOwner];
      eData = tData[mOwner];
      eWe = WrEn[mOwner];
      eRe = !WrEn[mOwner];
      if (!WrEn[mOwner]) begin
        dueQ.push_back(cyc + RL);
        exp_q.push_back(2'(mOwner));
      end
      mBeats++;
      if (Last[mOwner]) mOwn = 0;
      else if (mBeats == MB) begin
        mOwn = 0;
        eForced = 1;
      end
    end else begin
      mOwn = 0;
    end
    eGnt = mOwn ? (4'b0001 << mOwner) : 4'b0000;
    eBusy = mOwn;
  endtask

  initial begin
    forever begin
      @(posedge Clk or negedge Rst_n);
      if (!Rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process + monitors ----------------
  logic [3:0]    gntLog[$];
  logic [3:0]    prevGnt = '0;
  int            reCnt = 0, rdv1Cnt = 0, rdvAny = 0, forcedCnt = 0;
  logic [DW-1:0] lastRam = '0;

  initial begin
    logic [3:0] rv;
    forever begin
      @(negedge Clk);
      rv = 4'b0;
      if (dueQ.size() > 0 && dueQ[0] == cyc) begin
        rv = 4'b0001 << exp_q[0];
        void'(dueQ.pop_front());
        void'(exp_q.pop_front());
      end
      check("gnt", 32'(Gnt), 32'(eGnt));
      check("busy", 32'(Busy), 32'(eBusy));
      check("addr", 32'(AddressToRAM), 32'(eAddr));
      check("wdata", 32'(DataToRAM), 32'(eData));
      check("we", 32'(WriteEnableToRAM), 32'(eWe));
      check("re", 32'(ReadEnableToRAM), 32'(eRe));
      check("forced", 32'(ForcedRelease), 32'(eForced));
      check("rdvalid", 32'(RdValid), 32'(rv));
      check("rddata", 32'(RdData), 32'(lastRam));
      if (Gnt != 4'b0 && Gnt != prevGnt) gntLog.push_back(Gnt);
      prevGnt = Gnt;
      if (ReadEnableToRAM) reCnt++;
      if (RdValid == 4'b0010) rdv1Cnt++;
      if (RdValid != 4'b0) rdvAny++;
      if (ForcedRelease) forcedCnt++;
      lastRam = DW'($urandom_range(0, 65535));
      RamRdData = lastRam;
    end
  end

  function automatic logic [3:0] log_at(input int i);
    return (i < gntLog.size()) ? gntLog[i] : 4'b0000;
  endfunction

  task automatic clear_mon();
    gntLog.delete();
    reCnt = 0; rdv1Cnt = 0; rdvAny = 0; forcedCnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  task automatic burst(input int r, input int n, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic we, input logic useLast);
    int k = 0;
    int t = 0;
    logic acc;
    Req[r] = 1'b1;
    WrEn[r] = we;
    while (k < n && t < 100) begin
      tAddr[r] = a0 + AW'(k);
      tData[r] = d0 + DW'(k);
      Last[r] = useLast && (k == n - 1);
      acc = Gnt[r];
      @(negedge Clk);
      #1;
      if (acc) k++;
      t++;
    end
    Req[r] = 1'b0;
    Last[r] = 1'b0;
    check("burst_beats", 32'(k), 32'(n));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] exp2[2];
    logic [3:0] exp3[2];
    logic [3:0] exp5[5];
    int t;
    for (int i = 0; i < 4; i++) begin
      tAddr[i] = '0;
      tData[i] = '0;
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp2 = '{4'b1000, 4'b0001};
    exp5 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp2 = '{4'b0001, 4'b1000};
    exp5 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    exp3 = '{4'b0010, 4'b1000};

    idle(3);
    check("rst_gnt", 32'(Gnt), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    Rst_n = 1'b1;
    idle(2);

    // Single-beat write from requester 2.
    tAddr[2] = 16'h0040; tData[2] = 16'hBEEF; WrEn[2] = 1'b1; Last[2] = 1'b1; Req[2] = 1'b1;
    idle(1);
    check("t1_gnt", 32'(Gnt), 32'h4);
    idle(1);
    check("t1_addr", 32'(AddressToRAM), 32'h0040);
    check("t1_we", 32'(WriteEnableToRAM), 32'h1);
    check("t1_data", 32'(DataToRAM), 32'hBEEF);
    check("t1_gnt_off", 32'(Gnt), 32'h0);
    Req[2] = 1'b0; Last[2] = 1'b0;
    idle(3);

    // Requesters 0 and 3 contend.
    clear_mon();
    fork
      burst(0, 2, 16'h0100, 16'hA000, 1'b1, 1'b1);
      burst(3, 2, 16'h0300, 16'hC000, 1'b1, 1'b1);
    join
    idle(3);
    check("t2_first", 32'(log_at(0)), 32'(exp2[0]));
    check("t2_second", 32'(log_at(1)), 32'(exp2[1]));

    // Read burst from 1 with a write from 3 overlapping its returns.
    clear_mon();
    fork
      burst(1, 4, 16'h0010, 16'h0000, 1'b0, 1'b1);
      begin
        idle(1);
        burst(3, 1, 16'h0050, 16'h1234, 1'b1, 1'b1);
      end
    join
    idle(6);
    check("t3_re_cycles", 32'(reCnt), 32'd4);
    check("t3_rdv1_cycles", 32'(rdv1Cnt), 32'd4);
    check("t3_forced", 32'(forcedCnt), 32'd0);
    check("t3_first", 32'(log_at(0)), 32'(exp3[0]));
    check("t3_second", 32'(log_at(1)), 32'(exp3[1]));

    // Burst cap: four beats without Last.
    clear_mon();
    burst(0, MB, 16'h0200, 16'h5500, 1'b1, 1'b0);
    idle(3);
    check("t4_forced_pulses", 32'(forcedCnt), 32'd1);
    check("t4_grants", 32'(gntLog.size()), 32'd1);

    // Reset with a read in flight.
    tAddr[2] = 16'h0077; WrEn[2] = 1'b0; Last[2] = 1'b0; Req[2] = 1'b1;
    idle(2);
    check("t6_re_before", 32'(ReadEnableToRAM), 32'h1);
    #2 Rst_n = 1'b0;
    #1;
    check("t6_gnt", 32'(Gnt), 32'h0);
    check("t6_addr", 32'(AddressToRAM), 32'h0);
    check("t6_re", 32'(ReadEnableToRAM), 32'h0);
    check("t6_we", 32'(WriteEnableToRAM), 32'h0);
    check("t6_data", 32'(DataToRAM), 32'h0);
    check("t6_busy", 32'(Busy), 32'h0);
    check("t6_forced", 32'(ForcedRelease), 32'h0);
    check("t6_rdvalid", 32'(RdValid), 32'h0);
    Req[2] = 1'b0;
    idle(2);
    Rst_n = 1'b1;
    clear_mon();
    idle(6);
    check("t6_no_rdvalid", 32'(rdvAny), 32'd0);

    // All four requesting single-beat bursts.
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      tAddr[i] = AW'(16'h0400 + i);
      tData[i] = DW'(16'h0E00 + i);
    end
    WrEn = 4'hF; Last = 4'hF; Req = 4'hF;
    t = 0;
    while (gntLog.size() < 5 && t < 60) begin
      idle(1);
      t++;
    end
    Req = 4'h0; Last = 4'h0;
    idle(3);
    for (int i = 0; i < 5; i++) check("t5_order", 32'(log_at(i)), 32'(exp5[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
